// File: rtl/updown_counter_n.sv
// Up/down counter with a programmable modulus, wrap or saturate at the ends,
// synchronous clear/load, count enable, and boundary pulse plus sticky flag.
module updown_counter_n #(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             bnd,
   output logic             bnd_stky
);

   localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] ZERO_X = '0;

   logic [WIDTH-1:0] count_q, count_d;
   logic             bnd_q, bnd_d;
   logic             bnd_stky_q, bnd_stky_d;

   logic [WIDTH:0]   cur_x;
   logic [WIDTH:0]   nxt_x;
   logic [WIDTH:0]   lv_x;

   always_comb begin
      count_d    = count_q;
      bnd_d      = 1'b0;
      bnd_stky_d = bnd_stky_q;
      cur_x      = {1'b0, count_q};
      lv_x       = {1'b0, load_val};
      nxt_x      = cur_x;

      if (clr) begin
         count_d    = '0;
         bnd_stky_d = 1'b0;
      end else if (load) begin
         // out-of-range load values clamp to the top of the range
         count_d = (lv_x > MAX_X) ? MAX_X[WIDTH-1:0] : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (cur_x >= MAX_X) begin
               bnd_d      = 1'b1;
               bnd_stky_d = 1'b1;
               nxt_x      = (SATURATE != 0) ? cur_x : ZERO_X;
            end else begin
               nxt_x = cur_x + ONE_X;
            end
         end else begin
            if (cur_x == ZERO_X) begin
               bnd_d      = 1'b1;
               bnd_stky_d = 1'b1;
               nxt_x      = (SATURATE != 0) ? cur_x : MAX_X;
            end else begin
               nxt_x = cur_x - ONE_X;
            end
         end
         count_d = nxt_x[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         bnd_q      <= 1'b0;
         bnd_stky_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         bnd_q      <= bnd_d;
         bnd_stky_q <= bnd_stky_d;
      end
   end

   assign count    = count_q;
   assign bnd      = bnd_q;
   assign bnd_stky = bnd_stky_q;

endmodule
